bridge_host_cmd: RTL and testbench
==================================

# bridge_host_cmd

Host-side initiator for the 0xF8xxxxxx bridge command/status interface. Drives bridge write/read strobes to issue host→target commands (parameter write, `CM` semaphore, poll for `OK`, response readback) and, optionally, services target→host commands by polling the target mailbox and acknowledging them. Used as the host-side model in simulation benches and in cores that emulate the host end of the bridge.

## Interface
- `RD_LAT`, 1: cycles from the `bridge_rd` strobe cycle to the cycle in which `bridge_rd_data` is sampled.
- `POLL_GAP`, 8: idle cycles between consecutive status-poll reads.
- `TIMEOUT`, 65535: maximum poll reads per host command before abort.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: host command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_id` in 16: command code (e.g. 0x0000, 0x0011, 0x0080, 0x00A0).
- `cmd_param` in 32: value written to parameter word 0x20.
- `rsp_valid` out 1: one-cycle pulse, command finished.
- `rsp_code` out 16: result code from status word [15:0]; 0xFFFF on timeout.
- `rsp_timeout` out 1: qualifies `rsp_valid`; poll limit reached.
- `rsp_data0`, `rsp_data1`, `rsp_data2` out 32 each: response words 0x40/0x44/0x48.
- `bridge_addr` out 32; `bridge_wr` out 1; `bridge_wr_data` out 32; `bridge_rd` out 1; `bridge_rd_data` in 32.
- `tcmd_valid` out 1: one-cycle pulse, a target command was acknowledged.
- `tcmd_id` out 16: target command code (low 16 bits of target word 0).

## Operation
- All bridge data is byte-reversed on the bus. The logical value {b3,b2,b1,b0} is carried as {b0,b1,b2,b3} on both `bridge_wr_data` and `bridge_rd_data`. All constants below are logical values.
- Addresses:
  - Host status 0xF8000000; host parameter 0xF8000020.
  - Host responses 0xF8000040 / 0xF8000044 / 0xF8000048.
  - Target status 0xF8001000.
- States and transitions:
  - **IDLE**: on accept, latch `cmd_id`/`cmd_param` → **WR_PARAM**. Otherwise (macro on, gap counter expired) → **T_RD**.
  - **WR_PARAM**: write `cmd_param` to 0x20 → **WR_CMD**.
  - **WR_CMD**: write {0x434D, cmd_id} to 0x00. Clear the poll counter → **GAP**.
  - **GAP**: wait `POLL_GAP` cycles → **POLL**.
  - **POLL**: read 0x00. When sampled [31:16] == 0x4F4B, latch `rsp_code` = [15:0] → **RSP** (index 0). When the poll counter reaches `TIMEOUT` → **DONE** with `rsp_timeout`=1 and `rsp_code`=0xFFFF. Any other value → **GAP**. A sampled 0x4255 (busy) or a stale 0x434D counts as a poll.
  - **RSP**: read 0x40 + 4·index into `rsp_data`[index]; after index 2 → **DONE**.
  - **DONE**: pulse `rsp_valid` → IDLE.
  - **T_RD**: read 0xF8001000. If [31:16] == 0x636D, latch `tcmd_id` → **T_ACK**; else → IDLE and reload the gap counter.
  - **T_ACK**: write 0x6F6B0000 to 0xF8001000 and pulse `tcmd_valid` → IDLE.
- Only one bus strobe is active per cycle; `bridge_wr` and `bridge_rd` are never high together.
- `bridge_addr`/`bridge_wr_data` are held from the strobe cycle until the next access.
- Arbitration: a pending host command wins over a target poll that is due in the same cycle. An in-progress target poll/ack completes before a new command is accepted.
- Reset mid-operation: state → IDLE, counters cleared, no `rsp_valid` for the aborted command.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 in the first cycle after release.
  - `rsp_valid`, `rsp_timeout`, `tcmd_valid`, `bridge_wr`, `bridge_rd` = 0.
  - `rsp_code`, `rsp_data*`, `tcmd_id`, `bridge_addr`, `bridge_wr_data` = 0.
- Write access: 1 cycle.
- Read access: strobe cycle plus `RD_LAT` cycles. Data is sampled at the end of cycle strobe+`RD_LAT`.
- Minimum command latency, accept → `rsp_valid`: 2 (writes) + `POLL_GAP` + (1+`RD_LAT`) + 3·(1+`RD_LAT`) + 1. With defaults this is 19 cycles.
- Poll counter is 16 bits and saturates. Timeout fires after exactly `TIMEOUT` failed polls.
- `cmd_valid` is ignored outside IDLE; the caller holds it until `cmd_ready`.

## Configuration
- `BRIDGE_CMD_TARGET_SVC_EN` defined:
  - T_RD/T_ACK states and the gap-based target poll are present.
  - `tcmd_valid`/`tcmd_id` are live.
- Not defined:
  - Those states are removed and the block never accesses 0xF8001xxx.
  - `tcmd_valid`=0 and `tcmd_id`=0 constantly.

## Test plan
- Issue `cmd_id`=0x0011 with the target model booted → bus write {0x434D,0x0011} to 0x00. Expect `rsp_valid` with `rsp_code`=0x0000 and `rsp_timeout`=0, and the target's `reset_n` high.
- Issue `cmd_id`=0x0000 after boot_done=1 and setup_done=1 → `rsp_code`=0x0003.
- Issue `cmd_id`=0x1234 → `rsp_code`=0xFFFF with `rsp_timeout`=0.
- Issue `cmd_id`=0x00A0 with `cmd_param`=0, savestate_addr=0x12345678, size=0x100 → `rsp_data0`=1, `rsp_data1`=0x12345678, `rsp_data2`=0x100. Also check that bytes are reversed on the bus.
- Target model stuck returning 0x42550000 with `TIMEOUT`=4 → exactly 4 poll reads, then `rsp_timeout`=1 and `rsp_code`=0xFFFF.
- Macro on, target raises setup_done → target word reads 0x636D0140. Expect `tcmd_valid` with `tcmd_id`=0x0140, a write of 0x6F6B0000 to 0xF8001000, and the target returning to idle. Assert `reset_n`=0 during POLL → no `rsp_valid` and `cmd_ready`=1 after release.

Source files
------------

// File: rtl/bridge_host_cmd.sv
// bridge_host_cmd: host-side initiator for the 0xF8xxxxxx bridge command/status bus.
// Ports: clk, reset_n (sync, low); cmd_* request in; rsp_* result out;
//   bridge_* byte-reversed bus; tcmd_* target-command acknowledge pulse.
// Optional: `define BRIDGE_CMD_TARGET_SVC_EN adds target mailbox poll/ack.
module bridge_host_cmd #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_id,
  input  logic [31:0] cmd_param,
  output logic        rsp_valid,
  output logic [15:0] rsp_code,
  output logic        rsp_timeout,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic [31:0] rsp_data2,
  output logic [31:0] bridge_addr,
  output logic        bridge_wr,
  output logic [31:0] bridge_wr_data,
  output logic        bridge_rd,
  input  logic [31:0] bridge_rd_data,
  output logic        tcmd_valid,
  output logic [15:0] tcmd_id
);

  localparam logic [31:0] A_STAT  = 32'hF800_0000;
  localparam logic [31:0] A_PARAM = 32'hF800_0020;
  localparam logic [31:0] A_RSP   = 32'hF800_0040;
  localparam logic [31:0] A_TGT   = 32'hF800_1000;
  localparam logic [7:0]  PH_LAST = 8'(RD_LAT);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PARAM, S_WR_CMD, S_GAP, S_POLL,
    S_RSP, S_DONE, S_T_RD, S_T_ACK
  } state_t;

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t      state, state_n;
  logic [15:0] cmd_q;
  logic [31:0] param_q;
  logic [15:0] gap_cnt;
  logic [15:0] poll_cnt;
  logic [7:0]  ph;
  logic [1:0]  idx;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] a_addr, a_data;
  logic        wr, rd, samp, rd_state;
  logic [31:0] rd_word;
  logic        ok, poll_hit, tgt_due;

  assign rd_word  = swap(bridge_rd_data);
  assign ok       = rd_word[31:16] == 16'h4F4B;
  // Counts the poll being sampled now, so the limit is hit on exactly TIMEOUT reads.
  assign poll_hit = ({16'd0, poll_cnt} + 32'd1) >= TIMEOUT;
  assign samp     = ph == PH_LAST;
  assign rd_state = state == S_POLL || state == S_RSP || state == S_T_RD;

`ifdef BRIDGE_CMD_TARGET_SVC_EN
  logic [15:0] tgap;
  logic [15:0] tcmd_q;
  assign tgt_due    = tgap == 16'd0;
  assign tcmd_valid = state == S_T_ACK;
  assign tcmd_id    = tcmd_q;
`else
  assign tgt_due    = 1'b0;
  assign tcmd_valid = 1'b0;
  assign tcmd_id    = 16'd0;
`endif

  assign cmd_ready      = reset_n && state == S_IDLE;
  assign rsp_valid      = state == S_DONE;
  assign bridge_wr      = wr;
  assign bridge_rd      = rd;
  assign bridge_addr    = (wr || rd) ? a_addr : addr_q;
  assign bridge_wr_data = wr ? a_data : wdata_q;

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    rd      = 1'b0;
    a_addr  = addr_q;
    a_data  = wdata_q;
    unique case (state)
      S_IDLE: begin
        // Host command wins over a target poll due in the same cycle.
        if (cmd_valid) state_n = S_WR_PARAM;
        else if (tgt_due) state_n = S_T_RD;
      end
      S_WR_PARAM: begin
        wr      = 1'b1;
        a_addr  = A_PARAM;
        a_data  = swap(param_q);
        state_n = S_WR_CMD;
      end
      S_WR_CMD: begin
        wr      = 1'b1;
        a_addr  = A_STAT;
        a_data  = swap({16'h434D, cmd_q});
        state_n = S_GAP;
      end
      S_GAP: if (gap_cnt == GAP_LAST) state_n = S_POLL;
      S_POLL: begin
        rd     = ph == 8'd0;
        a_addr = A_STAT;
        if (samp) begin
          if (ok) state_n = S_RSP;
          else if (poll_hit) state_n = S_DONE;
          else state_n = S_GAP;
        end
      end
      S_RSP: begin
        rd     = ph == 8'd0;
        a_addr = A_RSP | {28'd0, idx, 2'b00};
        if (samp && idx == 2'd2) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
`ifdef BRIDGE_CMD_TARGET_SVC_EN
      S_T_RD: begin
        rd     = ph == 8'd0;
        a_addr = A_TGT;
        if (samp) begin
          if (rd_word[31:16] == 16'h636D) state_n = S_T_ACK;
          else state_n = S_IDLE;
        end
      end
      S_T_ACK: begin
        wr      = 1'b1;
        a_addr  = A_TGT;
        a_data  = swap(32'h6F6B_0000);
        state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      param_q     <= '0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      ph          <= '0;
      idx         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_code    <= '0;
      rsp_timeout <= 1'b0;
      rsp_data0   <= '0;
      rsp_data1   <= '0;
      rsp_data2   <= '0;
`ifdef BRIDGE_CMD_TARGET_SVC_EN
      tgap        <= '0;
      tcmd_q      <= '0;
`endif
    end else begin
      state <= state_n;
      if (wr || rd) addr_q <= a_addr;
      if (wr) wdata_q <= a_data;
      ph      <= (rd_state && !samp) ? ph + 8'd1 : 8'd0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == S_IDLE && cmd_valid) begin
        cmd_q       <= cmd_id;
        param_q     <= cmd_param;
        rsp_timeout <= 1'b0;
      end
      if (state == S_WR_CMD) poll_cnt <= '0;
      if (state == S_POLL && samp) begin
        if (ok) begin
          rsp_code <= rd_word[15:0];
          idx      <= '0;
        end else begin
          if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
          if (poll_hit) begin
            rsp_code    <= 16'hFFFF;
            rsp_timeout <= 1'b1;
          end
        end
      end
      if (state == S_RSP && samp) begin
        idx <= idx + 2'd1;
        unique case (idx)
          2'd0:    rsp_data0 <= rd_word;
          2'd1:    rsp_data1 <= rd_word;
          default: rsp_data2 <= rd_word;
        endcase
      end
`ifdef BRIDGE_CMD_TARGET_SVC_EN
      if (state == S_T_RD && samp) begin
        tgap <= 16'(POLL_GAP);
        if (rd_word[31:16] == 16'h636D) tcmd_q <= rd_word[15:0];
      end else if (state == S_IDLE && tgap != 16'd0) begin
        tgap <= tgap - 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bridge_host_cmd.sv
// tb_bridge_host_cmd: randomized scoreboard bench for bridge_host_cmd
// with a behavioural bridge target model (host status + target mailbox).
module tb_bridge_host_cmd;
  localparam int RD_LAT   = 1;
  localparam int POLL_GAP = 8;
  localparam int TIMEOUT  = 4;
  localparam int STUCK    = 1000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_id = '0;
  logic [31:0] cmd_param = '0;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_code;
  logic [31:0] rsp_data0, rsp_data1, rsp_data2;
  logic [31:0] bridge_addr, bridge_wr_data;
  logic        bridge_wr, bridge_rd;
  logic [31:0] bridge_rd_data = 32'hDEAD_BEEF;
  logic        tcmd_valid;
  logic [15:0] tcmd_id;

  bridge_host_cmd #(
    .RD_LAT(RD_LAT), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_param(cmd_param),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .rsp_timeout(rsp_timeout),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_data2(rsp_data2),
    .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
    .bridge_rd_data(bridge_rd_data),
    .tcmd_valid(tcmd_valid), .tcmd_id(tcmd_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  typedef struct {
    logic [15:0] code;
    logic [31:0] d0, d1, d2;
  } rsp_t;

  typedef struct {
    logic [15:0] code;
    logic        to;
    logic        chk_data;
    logic [31:0] d0, d1, d2;
    int          lat;
    int          polls;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] tq[$];
  int          done_cnt = 0;

  // Target firmware state
  logic        boot_done = 0, setup_done = 0, tgt_rst_n = 0;
  logic [31:0] ss_addr = 0, ss_size = 0;
  logic [31:0] tword = 0;
  int          acks = 0;
  int          busy_cfg = 0;
  logic [15:0] last_cmd = 0;
  logic [31:0] last_param = 0;

  // Host-side command semantics of the target firmware
  function automatic rsp_t fw_exec(input logic [15:0] c,
                                   input logic [31:0] p);
    rsp_t r;
    r = '{16'h0000, 32'd0, 32'd0, 32'd0};
    case (c)
      16'h0011: ;
      16'h0000: r.code = {14'd0, setup_done, boot_done};
      16'h00A0: begin r.d0 = 1; r.d1 = ss_addr; r.d2 = ss_size; end
      16'h0080: begin r.d0 = p; r.d1 = ~p; r.d2 = p + 1; end
      default:  r.code = 16'hFFFF;
    endcase
    return r;
  endfunction

  // Bus-side target model
  logic [31:0] t_param = 0;
  logic [15:0] t_cmd = 0;
  rsp_t        t_rsp;
  int          t_busy = 0, t_polls = 0;
  int          pend = 0;
  logic [31:0] pend_addr = 0;

  task automatic read_word(input logic [31:0] a, output logic [31:0] w);
    w = 32'h0;
    case (a)
      32'hF800_0000: begin
        t_polls++;
        if (t_busy > 0) begin
          t_busy--;
          w = (t_busy % 2 == 1) ? {16'h434D, t_cmd} : 32'h4255_0000;
        end else w = {16'h4F4B, t_rsp.code};
      end
      32'hF800_0040: w = t_rsp.d0;
      32'hF800_0044: w = t_rsp.d1;
      32'hF800_0048: w = t_rsp.d2;
      32'hF800_1000: w = tword;
      default: w = 32'h0;
    endcase
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] w);
    case (a)
      32'hF800_0020: t_param = w;
      32'hF800_0000: begin
        check("cm_word", w, {16'h434D, last_cmd});
        check("param_word", t_param, last_param);
        t_cmd   = w[15:0];
        t_polls = 0;
        t_busy  = busy_cfg;
        t_rsp   = fw_exec(t_cmd, t_param);
        if (t_cmd == 16'h0011) tgt_rst_n = 1;
      end
      32'hF800_1000: begin
        check("tack_word", w, 32'h6F6B_0000);
        tword = 0;
        acks++;
      end
      default: fail_now("write_addr");
    endcase
  endtask

  always @(negedge clk) begin
    logic [31:0] w;
    bridge_rd_data = 32'hDEAD_BEEF;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        read_word(pend_addr, w);
        bridge_rd_data = swap(w);
      end
    end
    if (reset_n && (bridge_wr || bridge_rd)) begin
      check("one_strobe", {31'd0, bridge_wr & bridge_rd}, 32'd0);
`ifndef BRIDGE_CMD_TARGET_SVC_EN
      if (bridge_addr[31:12] == 20'hF8001) fail_now("tgt_access_off");
`endif
      if (bridge_rd) begin
        pend_addr = bridge_addr;
        pend = RD_LAT;
      end
      if (bridge_wr) begin
        if (bridge_addr == 32'hF800_0000)
          check("cmd_raw_bytes", bridge_wr_data,
                {last_cmd[7:0], last_cmd[15:8], 8'h4D, 8'h43});
        do_write(bridge_addr, swap(bridge_wr_data));
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && rsp_valid) begin
      if (sbq.size() == 0) fail_now("unexpected_rsp_valid");
      else begin
        e = sbq.pop_front();
        check("rsp_code", {16'd0, rsp_code}, {16'd0, e.code});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
        if (e.chk_data) begin
          check("rsp_data0", rsp_data0, e.d0);
          check("rsp_data1", rsp_data1, e.d1);
          check("rsp_data2", rsp_data2, e.d2);
        end
        check("latency", cyc - e.acc + 1, e.lat);
        check("poll_reads", t_polls, e.polls);
        done_cnt++;
      end
    end
  end

  // Target-command monitor
  always @(negedge clk) begin
    if (reset_n) begin
`ifdef BRIDGE_CMD_TARGET_SVC_EN
      if (tcmd_valid) begin
        if (tq.size() == 0) fail_now("unexpected_tcmd_valid");
        else check("tcmd_id", {16'd0, tcmd_id}, {16'd0, tq.pop_front()});
      end
`else
      if (tcmd_valid !== 1'b0 || tcmd_id !== 16'd0)
        fail_now("tcmd_live_when_off");
`endif
    end
  end

  function automatic exp_t mk(input rsp_t r, input int busy);
    exp_t e;
    int   rd_cyc;
    rd_cyc     = 1 + RD_LAT;
    e.to       = busy >= TIMEOUT;
    e.polls    = e.to ? TIMEOUT : busy + 1;
    e.code     = e.to ? 16'hFFFF : r.code;
    e.chk_data = !e.to;
    e.d0       = r.d0;
    e.d1       = r.d1;
    e.d2       = r.d2;
    e.lat      = 2 + e.polls * (POLL_GAP + rd_cyc) + 1
               + (e.to ? 0 : 3 * rd_cyc);
    e.acc      = 0;
    return e;
  endfunction

  task automatic accept(input logic [15:0] id, input logic [31:0] prm,
                        input int busy, output int acc, output bit got);
    int k;
    busy_cfg   = busy;
    last_cmd   = id;
    last_param = prm;
    @(negedge clk);
    cmd_valid = 1;
    cmd_id    = id;
    cmd_param = prm;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    got = cmd_ready;
    acc = 0;
    if (got) begin
      @(posedge clk);
      #1 acc = cyc;
    end else fail_now("cmd_accept_wait");
    cmd_valid = 0;
  endtask

  task automatic issue(input logic [15:0] id, input logic [31:0] prm,
                       input int busy, input exp_t e);
    int k, d0, acc;
    bit got;
    d0 = done_cnt;
    accept(id, prm, busy, acc, got);
    if (got) begin
      e.acc = acc;
      sbq.push_back(e);
      k = 0;
      while (done_cnt == d0 && k < 400) begin
        @(negedge clk);
        k++;
      end
      if (done_cnt == d0) fail_now("rsp_valid_wait");
    end
  endtask

  task automatic raise_tcmd(input logic [15:0] id);
    int k, a0;
    a0 = acks;
    tq.push_back(id);
    tword = {16'h636D, id};
    k = 0;
    while (acks == a0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("tcmd_ack_seen", acks, a0 + 1);
    check("tgt_idle_after_ack", tword, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    rsp_t        r;
    logic [15:0] id;
    logic [31:0] prm;
    int          busy, acc, k;
    bit          got;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_flags", {27'd0, rsp_valid, rsp_timeout, tcmd_valid,
                        bridge_wr, bridge_rd}, 32'd0);
    check("rst_rsp_code", {16'd0, rsp_code}, 32'd0);
    check("rst_rsp_data", rsp_data0 | rsp_data1 | rsp_data2, 32'd0);
    check("rst_tcmd_id", {16'd0, tcmd_id}, 32'd0);
    check("rst_bus", bridge_addr | bridge_wr_data, 32'd0);
    reset_n = 1;
    #1 check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // boot
    issue(16'h0011, 32'h0000_0001, 2,
          mk('{16'h0000, 32'd0, 32'd0, 32'd0}, 2));
    check("tgt_reset_n", {31'd0, tgt_rst_n}, 32'd1);

    // status after boot+setup, minimum latency path
    boot_done  = 1;
    setup_done = 1;
    issue(16'h0000, 32'd0, 0, mk('{16'h0003, 32'd0, 32'd0, 32'd0}, 0));

    // unknown command
    issue(16'h1234, 32'hA5A5_5A5A, 1,
          mk('{16'hFFFF, 32'd0, 32'd0, 32'd0}, 1));

    // savestate info, one poll short of the limit
    ss_addr = 32'h1234_5678;
    ss_size = 32'h0000_0100;
    issue(16'h00A0, 32'd0, TIMEOUT - 1,
          mk('{16'h0000, 32'd1, 32'h1234_5678, 32'h100}, TIMEOUT - 1));

    // exactly at the poll limit, and stuck busy
    issue(16'h0080, 32'h0BAD_F00D, TIMEOUT,
          mk('{16'h0000, 32'd0, 32'd0, 32'd0}, TIMEOUT));
    issue(16'h0080, 32'h1111_2222, STUCK,
          mk('{16'h0000, 32'd0, 32'd0, 32'd0}, STUCK));

`ifdef BRIDGE_CMD_TARGET_SVC_EN
    raise_tcmd(16'h0140);
`endif

    // reset while polling: no response for the aborted command
    accept(16'h0080, 32'h5555_AAAA, STUCK, acc, got);
    k = 0;
    while (!(bridge_rd && bridge_addr == 32'hF800_0000) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_now("poll_not_reached");
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1 check("ready_after_mid_rst", {31'd0, cmd_ready}, 32'd1);
    repeat (40) @(negedge clk);
    t_busy = 0;

    for (int i = 0; i < 24; i++) begin
      boot_done  = 1'($urandom_range(0, 1));
      setup_done = 1'($urandom_range(0, 1));
      ss_addr    = $urandom;
      ss_size    = $urandom;
      case ($urandom_range(0, 4))
        0: id = 16'h0000;
        1: id = 16'h0011;
        2: id = 16'h0080;
        3: id = 16'h00A0;
        default: id = 16'h1000 + 16'($urandom_range(0, 255));
      endcase
      prm  = $urandom;
      busy = $urandom_range(0, TIMEOUT + 1);
      r    = fw_exec(id, prm);
      issue(id, prm, busy, mk(r, busy));
`ifdef BRIDGE_CMD_TARGET_SVC_EN
      if ($urandom_range(0, 2) == 0)
        raise_tcmd(16'($urandom_range(0, 16'hFFFF)));
`endif
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    check("tcmd_queue_empty", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
